// File: rtl/byte_rotate_loader.sv
// Serial-to-parallel feeder for the registered byte-rotation network: assembles N bytes,
// launches them with a per-level skewed select pipeline. Optional in_last: ROT_LOADER_LAST_EN.
module byte_rotate_loader #(
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
`ifdef ROT_LOADER_LAST_EN
    input  logic               in_last,
`endif
    input  logic [LOG2N-1:0]   rot_amt,
    output logic [N*8-1:0]     vec_out,
    output logic               vec_valid,
    output logic [LOG2N-1:0]   sel_out,
    output logic               net_valid
);

    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_LAUNCH = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               vec_valid_q, vec_valid_d;
    logic [LOG2N-1:0]   cnt_q, cnt_d;
    logic [LOG2N-1:0]   rot_q, rot_d;
    logic [N*8-1:0]     buf_q, buf_d;
    logic [N*8-1:0]     vec_q, vec_d;
    logic [LOG2N-1:0]   nv_q, nv_d;

    logic               xfer_s;
    logic               last_s;
    logic               done_s;
    logic [N*8-1:0]     fill_s;
    logic [LOG2N-1:0]   rot_eff_s;

`ifdef ROT_LOADER_LAST_EN
    assign last_s = in_last;
`else
    assign last_s = 1'b0;
`endif

    // in_ready_q is only ever high in FILL, so it doubles as the state qualifier
    assign xfer_s    = in_valid && in_ready_q;
    assign done_s    = xfer_s && ((cnt_q == LOG2N'(N-1)) || last_s);
    assign rot_eff_s = (cnt_q == '0) ? rot_amt : rot_q;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (done_s) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_LAUNCH: state_d = ST_FILL;
            default:   state_d = ST_FILL;
        endcase
    end

    // FSM output decode, taken from the next state so the outputs come straight off flops
    always_comb begin
        in_ready_d  = 1'b1;
        vec_valid_d = 1'b0;
        case (state_d)
            ST_FILL: begin
                in_ready_d  = 1'b1;
                vec_valid_d = 1'b0;
            end
            ST_LAUNCH: begin
                in_ready_d  = 1'b0;
                vec_valid_d = 1'b1;
            end
            default: begin
                in_ready_d  = 1'b1;
                vec_valid_d = 1'b0;
            end
        endcase
    end

    // Assembly datapath; lanes above cnt are always zero because the buffer clears on launch
    always_comb begin
        fill_s = buf_q;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == LOG2N'(i)) begin
                fill_s[i*8 +: 8] = in_data;
            end else begin
                fill_s[i*8 +: 8] = buf_q[i*8 +: 8];
            end
        end
        buf_d = buf_q;
        vec_d = vec_q;
        cnt_d = cnt_q;
        rot_d = rot_q;
        if (done_s) begin
            vec_d = fill_s;
            buf_d = '0;
            cnt_d = '0;
            rot_d = rot_eff_s;
        end else if (xfer_s) begin
            buf_d = fill_s;
            cnt_d = cnt_q + LOG2N'(1);
            rot_d = rot_eff_s;
        end else begin
            buf_d = buf_q;
            cnt_d = cnt_q;
            rot_d = rot_q;
        end
    end

    // net_valid delay line: vec_valid shifted LOG2N cycles
    always_comb begin
        nv_d    = nv_q << 1;
        nv_d[0] = vec_valid_q;
    end

    // Registered state for datapath, handshake and valid pipeline
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_q  <= 1'b1;
            vec_valid_q <= 1'b0;
            cnt_q       <= '0;
            rot_q       <= '0;
            buf_q       <= '0;
            vec_q       <= '0;
            nv_q        <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            vec_valid_q <= vec_valid_d;
            cnt_q       <= cnt_d;
            rot_q       <= rot_d;
            buf_q       <= buf_d;
            vec_q       <= vec_d;
            nv_q        <= nv_d;
        end
    end

    // Select bit k rides a (k+1)-deep line so it reaches level k together with the data
    for (genvar k = 0; k < LOG2N; k++) begin : g_sel
        logic [k:0] line_q;

        // Launch register plus k skew stages for select bit k
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                line_q <= '0;
            end else begin
                if (done_s) begin
                    line_q[0] <= rot_eff_s[k];
                end else begin
                    line_q[0] <= line_q[0];
                end
                for (int j = 1; j <= k; j++) begin
                    line_q[j] <= line_q[j-1];
                end
            end
        end

        assign sel_out[k] = line_q[k];
    end

    assign in_ready  = in_ready_q;
    assign vec_valid = vec_valid_q;
    assign vec_out   = vec_q;
    assign net_valid = nv_q[LOG2N-1];

endmodule
